i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target_pkg.sv | 19 +
 rtl/i2c_line_filter.sv | 39 +++
 rtl/i2c_target.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

    localparam int NUM_REGS = 4;
    localparam int PTR_W    = 2;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a stability filter; the output only follows
// the pad after FILTER_LEN consecutive samples at the new level.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rstN,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

    logic [1:0] r_sync;
    logic [2:0] r_cnt;
    logic       r_level;

    // Resets to 1 so the bus looks idle until real levels have been accepted.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a pointer register, three read/write control bytes and a
// read-only status byte. SCL is never driven; SDA is open-drain via SDA_OE.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR   = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        SCL_IN,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    output logic [23:0] ctrl_out,
    input  logic [7:0]  status_in,
    output logic        wr_pulse
);

    state_t                      r_state;
    state_t                      w_nextState;
    logic                        w_scl;
    logic                        w_sda;
    logic                        r_sclPrev;
    logic                        r_sdaPrev;
    logic                        w_sclRise;
    logic                        w_sclFall;
    logic                        w_start;
    logic                        w_stop;
    logic [7:0]                  r_shift;
    logic [3:0]                  r_bitCnt;
    logic                        r_rw;
    logic                        r_mNack;
    logic [PTR_W-1:0]            r_ptr;
    logic [(NUM_REGS-1)*8-1:0]   r_ctrl;
    logic [7:0]                  r_txByte;
    logic [7:0]                  w_rdByte;
    logic [7:0]                  w_rxByte;
    logic                        r_sdaOe;
    logic                        w_oeNext;
    logic                        r_wrPulse;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sclFilter (
        .i_clk   (clk),
        .i_rstN  (RESET_N),
        .i_raw   (SCL_IN),
        .o_level (w_scl)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sdaFilter (
        .i_clk   (clk),
        .i_rstN  (RESET_N),
        .i_raw   (SDA_IN),
        .o_level (w_sda)
    );

    assign w_sclRise = w_scl & ~r_sclPrev;
    assign w_sclFall = ~w_scl & r_sclPrev;
    assign w_start   = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
    assign w_stop    = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
    assign w_rxByte  = {r_shift[6:0], w_sda};

    always_comb begin
        case (r_ptr)
            2'd0:    w_rdByte = r_ctrl[7:0];
            2'd1:    w_rdByte = r_ctrl[15:8];
            2'd2:    w_rdByte = r_ctrl[23:16];
            default: w_rdByte = status_in;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_sdaOe <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_sdaOe <= w_oeNext;
        end
    end

    // Every state advances on an SCL falling edge, so SDA_OE only moves there.
    always_comb begin
        w_nextState = r_state;
        w_oeNext    = r_sdaOe;
        if (w_stop) begin
            w_nextState = IDLE;
            w_oeNext    = 1'b0;
        end else if (w_start) begin
            w_nextState = ADDR;
            w_oeNext    = 1'b0;
        end else if (w_sclFall) begin
            case (r_state)
                ADDR: begin
                    if (r_bitCnt == 4'd8) begin
                        if (r_shift[7:1] == I2C_ADDR) begin
                            w_nextState = ADDR_ACK;
                            w_oeNext    = 1'b1;
                        end else begin
                            w_nextState = IDLE;
                            w_oeNext    = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (r_rw) begin
                        w_nextState = RD_DATA;
                        w_oeNext    = ~w_rdByte[7];
                    end else begin
                        w_nextState = PTR;
                        w_oeNext    = 1'b0;
                    end
                end
                PTR: begin
                    if (r_bitCnt == 4'd8) begin
                        if (r_shift[7:2] != 6'd0) begin
                            w_nextState = IDLE;
                            w_oeNext    = 1'b0;
                        end else begin
                            w_nextState = PTR_ACK;
                            w_oeNext    = 1'b1;
                        end
                    end
                end
                PTR_ACK, WR_ACK: begin
                    w_nextState = WR_DATA;
                    w_oeNext    = 1'b0;
                end
                WR_DATA: begin
                    if (r_bitCnt == 4'd8) begin
                        w_nextState = WR_ACK;
                        w_oeNext    = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (r_bitCnt == 4'd8) begin
                        w_nextState = RD_ACK;
                        w_oeNext    = 1'b0;
                    end else begin
                        w_oeNext = ~r_txByte[6];
                    end
                end
                RD_ACK: begin
                    if (r_mNack) begin
                        w_nextState = IDLE;
                        w_oeNext    = 1'b0;
                    end else begin
                        w_nextState = RD_DATA;
                        w_oeNext    = ~w_rdByte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_rw      <= 1'b0;
            r_mNack   <= 1'b0;
            r_ptr     <= '0;
            r_ctrl    <= '0;
            r_txByte  <= '0;
            r_wrPulse <= 1'b0;
        end else begin
            r_sclPrev <= w_scl;
            r_sdaPrev <= w_sda;
            r_wrPulse <= 1'b0;
            if (w_start || w_stop) begin
                r_bitCnt <= '0;
            end else if (w_sclRise) begin
                case (r_state)
                    ADDR, PTR, WR_DATA: begin
                        r_shift  <= w_rxByte;
                        r_bitCnt <= r_bitCnt + 4'd1;
                        // The top byte slot is read-only status, so writes there only advance ptr.
                        if (r_state == WR_DATA && r_bitCnt == 4'd7) begin
                            r_ptr <= r_ptr + PTR_W'(1);
                            case (r_ptr)
                                2'd0:    begin r_ctrl[7:0]   <= w_rxByte; r_wrPulse <= 1'b1; end
                                2'd1:    begin r_ctrl[15:8]  <= w_rxByte; r_wrPulse <= 1'b1; end
                                2'd2:    begin r_ctrl[23:16] <= w_rxByte; r_wrPulse <= 1'b1; end
                                default: ;
                            endcase
                        end
                    end
                    RD_DATA: r_bitCnt <= r_bitCnt + 4'd1;
                    RD_ACK: begin
                        r_mNack <= w_sda;
                        if (!w_sda) begin
                            r_ptr <= r_ptr + PTR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end else if (w_sclFall) begin
                case (r_state)
                    ADDR: begin
                        if (r_bitCnt == 4'd8) begin
                            r_bitCnt <= '0;
                            r_rw     <= r_shift[0];
                        end
                    end
                    ADDR_ACK: begin
                        r_bitCnt <= '0;
                        if (r_rw) begin
                            r_txByte <= w_rdByte;
                        end
                    end
                    PTR: begin
                        if (r_bitCnt == 4'd8) begin
                            r_bitCnt <= '0;
                            if (r_shift[7:2] == 6'd0) begin
                                r_ptr <= r_shift[PTR_W-1:0];
                            end
                        end
                    end
                    WR_DATA: begin
                        if (r_bitCnt == 4'd8) begin
                            r_bitCnt <= '0;
                        end
                    end
                    RD_DATA: begin
                        if (r_bitCnt == 4'd8) begin
                            r_bitCnt <= '0;
                        end else begin
                            r_txByte <= {r_txByte[6:0], 1'b0};
                        end
                    end
                    RD_ACK: begin
                        if (!r_mNack) begin
                            r_txByte <= w_rdByte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA_OE   = r_sdaOe;
    assign ctrl_out = r_ctrl;
    assign wr_pulse = r_wrPulse;

endmodule
